// File: rtl/nmi2apb_pkg.sv
// Shared types and constants for the NMI-to-APB bridge.
//   nmi2apb_state_e : bridge FSM state encoding
//   ERR_RDATA       : read data returned on a failed transfer
package nmi2apb_pkg;

  // state  | meaning
  // IDLE   | waiting for nmi.valid, APB outputs hold last transfer
  // SETUP  | psel=1, penable=0, timeout counter cleared
  // ACCESS | psel=1, penable=1, waiting for pready or timeout
  // ACK    | one-cycle nmi.ready with latched rdata/err
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } nmi2apb_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_if.sv
// Native memory interface (NMI) bundle between the bus decoder and a responder.
//   valid/addr/wdata/wstrb : request, held stable by the master until ready
//   ready/rdata            : one-cycle completion with read data
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input ready, input rdata);
  modport slave  (input valid, input addr, input wdata, input wstrb,
                  output ready, output rdata);
endinterface

// File: rtl/nmi2apb_bridge.sv
// NMI responder that turns each NMI request into one APB3 transfer
// (SETUP, ACCESS with wait states) and returns a one-cycle ready.
// A down-the-line hung completer is cut off after TIMEOUT_CYCLES ACCESS cycles.
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   nmi              : NMI slave port (valid/addr/wdata/wstrb in, ready/rdata out)
//   apb_*_o          : APB requester outputs (psel, penable, pwrite, paddr, pwdata, pstrb)
//   apb_*_i          : APB completer responses (prdata, pready, pslverr)
//   err_o            : pulse alongside nmi.ready when the transfer failed
module nmi2apb_bridge
  import nmi2apb_pkg::*;
#(
  parameter int APB_ADDR_W     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  nmi_if.slave                  nmi,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [APB_ADDR_W-1:0] apb_paddr_o,
  output logic [31:0]           apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic [31:0]           apb_prdata_i,
  input  logic                  apb_pready_i,
  input  logic                  apb_pslverr_i,
  output logic                  err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds the index of the current ACCESS cycle, so the last
  // permitted cycle is index TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  nmi2apb_state_e state;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic [31:0]      rdata_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      apb_psel_o    <= 1'b0;
      apb_penable_o <= 1'b0;
      apb_pwrite_o  <= 1'b0;
      apb_paddr_o   <= '0;
      apb_pwdata_o  <= '0;
      apb_pstrb_o   <= '0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      err_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (nmi.valid) begin
            apb_paddr_o  <= nmi.addr[APB_ADDR_W-1:0];
            apb_pwdata_o <= nmi.wdata;
            apb_pstrb_o  <= nmi.wstrb;
            apb_pwrite_o <= |nmi.wstrb;
            apb_psel_o   <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          apb_penable_o <= 1'b1;
          cnt           <= '0;
          state         <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over expiry in the same cycle.
          if (apb_pready_i) begin
            if (apb_pwrite_o)       rdata_q <= '0;
            else if (apb_pslverr_i) rdata_q <= ERR_RDATA;
            else                    rdata_q <= apb_prdata_i;
            err_o         <= apb_pslverr_i;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            ready_q       <= 1'b1;
            state         <= ACK;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            rdata_q       <= ERR_RDATA;
            err_o         <= 1'b1;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            ready_q       <= 1'b1;
            state         <= ACK;
          end else if (TIMEOUT_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACK: begin
          // valid seen here belongs to the finished transfer; ignore it.
          ready_q <= 1'b0;
          err_o   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign nmi.ready = ready_q;
  assign nmi.rdata = rdata_q;

endmodule

// File: tb/tb_nmi2apb_bridge.sv
module tb_nmi2apb_bridge;
  import nmi2apb_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel, penable, pwrite, err;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  nmi_if nmi ();

  nmi2apb_bridge #(.APB_ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .nmi(nmi),
    .apb_psel_o(psel), .apb_penable_o(penable), .apb_pwrite_o(pwrite),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb),
    .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one NMI transfer starting in the current cycle (cycle 0).
  // waits < 0 means the completer never answers.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input int waits, input logic [31:0] rd, input logic se,
                      input bit keep_valid);
    exp_t e;
    bit   tmo;
    bit   seen;
    int   acc;
    tmo     = (waits < 0) || (waits >= TO);
    e.err   = tmo || se;
    e.rdata = tmo ? ERR_RDATA : ((ws != 4'h0) ? 32'h0 : (se ? ERR_RDATA : rd));
    e.lat   = tmo ? TO + 2 : 3 + waits;
    sb.push_back(e);

    nmi.valid = 1'b1;
    nmi.addr  = a;
    nmi.wdata = wd;
    nmi.wstrb = ws;
    acc  = 0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk); #1;
      pready = 1'b0;
      if (cyc == 1) begin
        chk("setup_psel", {31'h0, psel}, 32'h1);
        chk("setup_penable", {31'h0, penable}, 32'h0);
      end
      if (psel && penable) begin
        chk("acc_pwdata", pwdata, wd);
        chk("acc_pstrb", {28'h0, pstrb}, {28'h0, ws});
        chk("acc_pwrite", {31'h0, pwrite}, {31'h0, (ws != 4'h0)});
        chk("acc_paddr", paddr, a);
        pready  = (waits >= 0) && (acc >= waits);
        prdata  = rd;
        pslverr = se;
        acc++;
      end
      if (nmi.ready) begin
        seen = 1'b1;
        chk("sb_nonempty", {31'h0, (sb.size() != 0)}, 32'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rdata", nmi.rdata, e.rdata);
          chk("err", {31'h0, err}, {31'h0, e.err});
          chk("latency", cyc, e.lat);
          chk("ack_psel", {31'h0, psel}, 32'h0);
          chk("ack_penable", {31'h0, penable}, 32'h0);
        end
      end
    end
    if (!seen) chk("ready_seen", 32'h0, 32'h1);
    @(posedge clk); #1;
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("ready_one_cycle", {31'h0, nmi.ready}, 32'h0);
    chk("err_one_cycle", {31'h0, err}, 32'h0);
    chk("idle_psel", {31'h0, psel}, 32'h0);
    chk("idle_pwdata_hold", pwdata, wd);
    if (!keep_valid) begin
      nmi.valid = 1'b0;
      nmi.wstrb = 4'h0;
    end
  endtask

  initial begin
    nmi.valid = 1'b0;
    nmi.addr  = '0;
    nmi.wdata = '0;
    nmi.wstrb = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;

    #12;
    chk("rst_psel", {31'h0, psel}, 32'h0);
    chk("rst_penable", {31'h0, penable}, 32'h0);
    chk("rst_ready", {31'h0, nmi.ready}, 32'h0);
    chk("rst_rdata", nmi.rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait read
    xfer(32'h1000_0010, 32'h0, 4'h0, 0, 32'hA5A5_0001, 1'b0, 1'b0);
    // write, 3 wait states
    xfer(32'h1000_0020, 32'h1234_5678, 4'b0110, 3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // PSLVERR read
    xfer(32'h1000_0030, 32'h0, 4'h0, 1, 32'h1111_2222, 1'b1, 1'b0);
    // PSLVERR write: error flagged, rdata 0
    xfer(32'h1000_0034, 32'hCAFE_0000, 4'b1111, 0, 32'h3333_4444, 1'b1, 1'b0);
    // timeout, completer stuck
    xfer(32'h1000_0040, 32'h0, 4'h0, -1, 32'h5555_6666, 1'b0, 1'b0);
    // timeout on a write
    xfer(32'h1000_0044, 32'h0BAD_0001, 4'b0001, -1, 32'h0, 1'b0, 1'b0);
    // pready on the 4th ACCESS cycle beats the expiry
    xfer(32'h1000_0050, 32'h0, 4'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);

    // reset during ACCESS
    nmi.valid = 1'b1;
    nmi.addr  = 32'h1000_0060;
    nmi.wstrb = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_penable", {31'h0, penable}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_psel", {31'h0, psel}, 32'h0);
    chk("async_penable", {31'h0, penable}, 32'h0);
    chk("async_ready", {31'h0, nmi.ready}, 32'h0);
    nmi.valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_ready", {31'h0, nmi.ready}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h1000_0070, 32'h0, 4'h0, 0, 32'h7777_8888, 1'b0, 1'b0);

    // back-to-back reads, valid reasserted right after ready
    xfer(32'h1000_0080, 32'h0, 4'h0, 0, 32'h0000_0081, 1'b0, 1'b1);
    xfer(32'h1000_0084, 32'h0, 4'h0, 0, 32'h0000_0085, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmi2apb_bridge.md
# nmi2apb_bridge

Responder-side bridge that terminates the native memory interface (NMI) master port driven by the SoC bus decoder for the flash and custom-IP address windows. It converts each NMI transaction into a single APB3-style transfer (SETUP, then ACCESS with wait states) on the peripheral bus. It returns read data and a one-cycle `ready` to the core. A timeout counter guarantees that a hung peripheral cannot stall the core forever.

## Interface
Parameters:
- `APB_ADDR_W`, 32: width of `apb_paddr_o`, taken from `nmi.addr[APB_ADDR_W-1:0]`.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `nmi`  nmi_if.slave  —  fields `valid`, `addr[31:0]`, `wdata[31:0]`, `wstrb[3:0]` in; `ready`, `rdata[31:0]` out.
- `apb_psel_o`  out  1  APB select.
- `apb_penable_o`  out  1  APB enable.
- `apb_pwrite_o`  out  1  1 = write.
- `apb_paddr_o`  out  APB_ADDR_W  address.
- `apb_pwdata_o`  out  32  write data.
- `apb_pstrb_o`  out  4  byte strobes.
- `apb_prdata_i`  in  32  read data.
- `apb_pready_i`  in  1  completer ready.
- `apb_pslverr_i`  in  1  completer error.
- `err_o`  out  1  one-cycle pulse, coincident with `nmi.ready`, when the transfer ended with PSLVERR or timeout.

## Operation
- Write when `|nmi.wstrb`, otherwise read.
- NMI rule: master holds `valid`/`addr`/`wdata`/`wstrb` stable until `ready`, then drops or changes them the next cycle. `ready` is high for exactly one cycle per transaction.
- FSM states, held in the package enum: IDLE, SETUP, ACCESS, ACK.
  - IDLE: on `nmi.valid`, latch `addr`, `wdata`, `wstrb` and pwrite into registers; go to SETUP.
  - SETUP: `psel=1`, `penable=0`; clear the timeout counter; go to ACCESS.
  - ACCESS: `psel=1`, `penable=1`; counter increments each cycle.
    - `pready=1`: latch `prdata` (reads only; writes latch 0) and error = `pslverr`; go to ACK.
    - Counter reaches `TIMEOUT_CYCLES` with `pready=0`: latch `rdata=ERR_RDATA` and error=1; go to ACK.
  - ACK: `psel=0`, `penable=0`, `nmi.ready=1`, `nmi.rdata` = latched value, `err_o` = latched error; go to IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational path from APB inputs to NMI outputs.
- APB address, data, strobe and write outputs hold the latched values from SETUP through ACK. They retain their last values in IDLE.
- No pipelining: one outstanding transfer at a time. `valid` arriving in ACK is ignored, and IDLE relaunches only when `valid` is seen in IDLE.
- Error response: `rdata` = `ERR_RDATA` on PSLVERR for reads; on timeout, for both reads and writes.

## Timing
- Reset values: all outputs 0, FSM=IDLE, counter=0, latched regs 0. Reset is asynchronous, so `psel`/`penable` fall immediately even mid-transfer; no ACK is issued for an aborted transfer.
- Latency, `valid` at cycle 0 (IDLE) with zero-wait completer: SETUP c1, ACCESS c2 (`pready` sampled), ACK c3 (`nmi.ready`).
  - Minimum latency is 3 cycles; each APB wait state adds 1.
- Timeout: with `TIMEOUT_CYCLES=N`, abort on the N-th ACCESS cycle without `pready`, so `ready` arrives at cycle N+2.
  - `pready` in the same cycle as expiry wins (normal completion).
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` (min 1). It never wraps, because the FSM leaves ACCESS at the limit.
- Back-to-back transfers: next SETUP is no earlier than 2 cycles after ACK (IDLE sample, then SETUP).

## Structure
- `nmi2apb_pkg`: state enum `nmi2apb_state_e`; constant `ERR_RDATA = 32'hDEAD_BEEF`.
- No sub-module required. Flops may use the codebase's `dffr`/`dffer` cells.
- Instantiated behind the bus decoder's APB-window NMI master port.

## Test plan
- Read, zero-wait: `addr=0x1000_0010`, `wstrb=0`, completer `prdata=0xA5A5_0001` -> `psel` c1, `penable` c2, `ready`+`rdata=0xA5A5_0001` c3, `err_o=0`, `pwrite=0`.
- Write with 3 wait states: `wstrb=4'b0110`, `wdata=0x1234_5678` -> `pstrb=0110`, `pwdata` stable through ACCESS, `ready` at c6, `rdata=0`.
- PSLVERR on read -> `ready` with `rdata=0xDEAD_BEEF`, `err_o=1` for exactly 1 cycle.
- Timeout, `TIMEOUT_CYCLES=4`, `pready` stuck 0 -> `ready` and `err_o` at c6, `psel` low in ACK. Repeat with `pready` rising on the 4th ACCESS cycle -> normal completion, `err_o=0`.
- Reset asserted during ACCESS -> `psel`/`penable`/`ready` go 0 asynchronously. After release, a new read completes normally in 3 cycles.
- Back-to-back reads with `valid` re-asserted the cycle after `ready` -> exactly one `ready` per transfer, second SETUP 2 cycles after first ACK.
